// File: rtl/instr_prefetch_pkg.sv
// Shared definitions for the instruction prefetch front-end: word width,
// the NOP filler word and the fetch FSM state encoding.
package instr_prefetch_pkg;

  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_WORD_DEF = 16'h3FC1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

endpackage

// File: rtl/instr_prefetch_fifo.sv
// Circular buffer holding prefetched {word, address} pairs; pointers wrap
// modulo DEPTH (a power of two), flush empties it in one cycle.
module instr_prefetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign head   = mem[rd_ptr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/instr_prefetch.sv
// Instruction fetch front-end: runs ahead of the core over a req/ack port,
// queues fetched words, flushes on redirect and shows NOP when empty.
module instr_prefetch
  import instr_prefetch_pkg::*;
#(
  parameter int                  DEPTH    = 4,
  parameter int                  ADDR_W   = 16,
  parameter logic [INSTR_W-1:0]  NOP_WORD = NOP_WORD_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   imem_req,
  output logic [ADDR_W-1:0]      imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_W-1:0]     imem_data,
  input  logic                   redirect,
  input  logic [ADDR_W-1:0]      redirect_pc,
  input  logic                   take,
  output logic [INSTR_W-1:0]     instr,
  output logic [ADDR_W-1:0]      instr_pc,
  output logic                   instr_valid,
  output logic [$clog2(DEPTH):0] count
);

  localparam int                CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0]  ONE_C   = CNT_W'(1);

  state_t                       state, state_nxt;
  logic [ADDR_W-1:0]            fetch_pc, fetch_pc_nxt, addr_nxt;
  logic                         req_nxt;
  logic                         push, pop, space_after;
  logic [INSTR_W+ADDR_W-1:0]    head;

  // A pending request already owns a slot, so after a push the occupancy
  // (net of this cycle's pop) must leave room before issuing the next one.
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    addr_nxt     = imem_addr;
    req_nxt      = imem_req;
    push         = 1'b0;
    pop          = take && instr_valid && !redirect;
    space_after  = (count + ONE_C - {{(CNT_W-1){1'b0}}, pop}) < DEPTH_C;
    case (state)
      ST_IDLE: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
        end else if (count < DEPTH_C) begin
          state_nxt = ST_REQ;
          req_nxt   = 1'b1;
          addr_nxt  = fetch_pc;
        end
      end
      ST_REQ: begin
        if (redirect) begin
          fetch_pc_nxt = redirect_pc;
          if (imem_ack) begin
            state_nxt = ST_IDLE;
            req_nxt   = 1'b0;
          end else begin
            state_nxt = ST_DISCARD;
          end
        end else if (imem_ack) begin
          push         = 1'b1;
          fetch_pc_nxt = fetch_pc + ADDR_W'(1);
          if (space_after) begin
            addr_nxt = fetch_pc + ADDR_W'(1);
          end else begin
            state_nxt = ST_IDLE;
            req_nxt   = 1'b0;
          end
        end
      end
      ST_DISCARD: begin
        if (redirect) fetch_pc_nxt = redirect_pc;
        if (imem_ack) begin
          state_nxt = ST_IDLE;
          req_nxt   = 1'b0;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      fetch_pc  <= '0;
      imem_addr <= '0;
      imem_req  <= 1'b0;
    end else begin
      state     <= state_nxt;
      fetch_pc  <= fetch_pc_nxt;
      imem_addr <= addr_nxt;
      imem_req  <= req_nxt;
    end
  end

  instr_prefetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (INSTR_W + ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect),
    .wdata ({imem_data, imem_addr}),
    .head  (head),
    .count (count)
  );

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? head[INSTR_W+ADDR_W-1:ADDR_W] : NOP_WORD;
  assign instr_pc    = instr_valid ? head[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_instr_prefetch.sv
// Bench for instr_prefetch: directed scenarios plus randomized traffic checked
// against a queue-based model of the fetch stream and FIFO contents.
module tb_instr_prefetch;

  localparam logic [15:0] NOP = 16'h3FC1;
  localparam int          DEPTH = 4;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        take;
  logic [15:0] instr;
  logic [15:0] instr_pc;
  logic        instr_valid;
  logic [2:0]  count;

  instr_prefetch #(.DEPTH(DEPTH), .ADDR_W(16), .NOP_WORD(NOP)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_data   (imem_data),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .take        (take),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .count       (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          lat;
  int          age;
  bit          take_v, redir_v, force_ack;
  logic [15:0] redir_pc_v;
  logic [31:0] q[$];
  logic [15:0] exp_pc;
  bit          m_discard;
  bit          held;
  logic [15:0] held_addr;
  logic [15:0] exp4 [4];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] rom(input logic [15:0] a);
    return a + 16'h0100;
  endfunction

  task automatic model_check();
    chk("count", 32'(count), 32'(q.size()));
    chk("valid", 32'(instr_valid), (q.size() != 0) ? 32'd1 : 32'd0);
    chk("instr", 32'(instr), (q.size() != 0) ? 32'(q[0][31:16]) : 32'(NOP));
    chk("instr_pc", 32'(instr_pc), (q.size() != 0) ? 32'(q[0][15:0]) : 32'd0);
    if (imem_req && !m_discard) chk("fetch_addr", 32'(imem_addr), 32'(exp_pc));
    if (held) begin
      chk("hold_req", 32'(imem_req), 32'd1);
      chk("hold_addr", 32'(imem_addr), 32'(held_addr));
    end
  endtask

  // One clock: drive inputs, advance the reference model over the edge, check.
  task automatic step();
    logic ack;
    ack         = (imem_req && age >= lat) || force_ack;
    imem_ack    = ack;
    imem_data   = (imem_req && ack) ? rom(imem_addr) : 16'($urandom);
    take        = take_v;
    redirect    = redir_v;
    redirect_pc = redir_pc_v;
    if (redir_v) begin
      q.delete();
      m_discard = imem_req && !ack;
      exp_pc    = redir_pc_v;
    end else begin
      if (take_v && q.size() != 0) void'(q.pop_front());
      if (imem_req && ack) begin
        if (m_discard) m_discard = 1'b0;
        else begin
          q.push_back({rom(imem_addr), imem_addr});
          exp_pc = exp_pc + 16'd1;
        end
      end
    end
    held      = imem_req && !ack;
    held_addr = imem_addr;
    age       = (imem_req && !ack) ? age + 1 : 0;
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    imem_ack = 1'b0;
    take     = 1'b0;
    redirect = 1'b0;
    #2;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_instr", 32'(instr), 32'(NOP));
    chk("rst_pc", 32'(instr_pc), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    q.delete();
    exp_pc    = 16'd0;
    m_discard = 1'b0;
    age       = 0;
    held      = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_data = 16'h0; redirect = 1'b0;
    redirect_pc = 16'h0; take = 1'b0;
    lat = 0; take_v = 1'b0; redir_v = 1'b0; force_ack = 1'b0; redir_pc_v = 16'h0;
    exp4 = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    #1;
    do_reset();

    // Fill from a zero-wait ROM without consuming
    repeat (8) step();
    chk("t1_count", 32'(count), 32'd4);
    chk("t1_req", 32'(imem_req), 32'd0);
    chk("t1_instr", 32'(instr), 32'h0100);
    chk("t1_pc", 32'(instr_pc), 32'd0);

    // Continuous consumption: one word per cycle
    take_v = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("t2_pc", 32'(instr_pc), 32'(k));
      chk("t2_valid", 32'(instr_valid), 32'd1);
      step();
    end
    chk("t2_count", 32'(count), 32'd2);
    take_v = 1'b0;

    // Redirect latency and address wrap
    redir_v = 1'b1; redir_pc_v = 16'hFFFE; step(); redir_v = 1'b0;
    chk("t4_flush_count", 32'(count), 32'd0);
    chk("t4_flush_valid", 32'(instr_valid), 32'd0);
    step();
    chk("lat_req", 32'(imem_req), 32'd1);
    chk("lat_addr", 32'(imem_addr), 32'hFFFE);
    step();
    chk("lat_valid", 32'(instr_valid), 32'd1);
    chk("lat_pc", 32'(instr_pc), 32'hFFFE);
    repeat (6) step();
    take_v = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t4_wrap_pc", 32'(instr_pc), 32'(exp4[k]));
      step();
    end
    take_v = 1'b0;

    // Redirect and take together with three words queued
    do_reset();
    for (int i = 0; i < 10 && count != 3'd3; i++) step();
    chk("t5_fill", 32'(count), 32'd3);
    redir_v = 1'b1; take_v = 1'b1; redir_pc_v = 16'h0200; step();
    redir_v = 1'b0; take_v = 1'b0;
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_instr", 32'(instr), 32'(NOP));
    chk("t5_valid", 32'(instr_valid), 32'd0);
    step(); step();
    chk("t5_new_pc", 32'(instr_pc), 32'h0200);
    chk("t5_new_instr", 32'(instr), 32'h0300);

    // Slow memory: redirect while a request is outstanding
    do_reset();
    lat = 2;
    step();
    chk("t3_req", 32'(imem_req), 32'd1);
    step();
    redir_v = 1'b1; redir_pc_v = 16'h0040; step(); redir_v = 1'b0;
    chk("t3_hold_addr", 32'(imem_addr), 32'd0);
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    chk("t3_got_valid", 32'(instr_valid), 32'd1);
    chk("t3_first_pc", 32'(instr_pc), 32'h0040);
    chk("t3_first_instr", 32'(instr), 32'h0140);

    // Reset mid-request, stray ack right after release
    do_reset();
    step();
    chk("t6_req_before", 32'(imem_req), 32'd1);
    do_reset();
    force_ack = 1'b1; step(); force_ack = 1'b0;
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_req", 32'(imem_req), 32'd1);
    chk("t6_addr", 32'(imem_addr), 32'd0);
    for (int i = 0; i < 20 && !instr_valid; i++) step();
    chk("t6_pc", 32'(instr_pc), 32'd0);
    chk("t6_instr", 32'(instr), 32'h0100);

    // Randomized traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (c % 64 == 0) lat = $urandom_range(0, 3);
      take_v     = ($urandom_range(0, 3) != 0);
      redir_v    = ($urandom_range(0, 19) == 0);
      redir_pc_v = ($urandom_range(0, 3) == 0) ? 16'hFFFD + 16'($urandom_range(0, 3))
                                               : 16'($urandom);
      force_ack  = !imem_req && ($urandom_range(0, 9) == 0);
      step();
    end
    force_ack = 1'b0; redir_v = 1'b0; take_v = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
